// File: rtl/rx78_video_scan.sv
// Raster scanout: video timing, three-bitplane VRAM fetch and LSB-first pixel serialiser.
// Optional border colour during blanking is enabled by defining RX78_BORDER_COLOR_EN.
module rx78_video_scan #(
  parameter int ADDR_WIDTH = 14,
  parameter int H_TOTAL    = 320,
  parameter int H_START    = 80,
  parameter int H_ACTIVE   = 192,
  parameter int HS_START   = 8,
  parameter int HS_WIDTH   = 24,
  parameter int V_TOTAL    = 262,
  parameter int V_START    = 40,
  parameter int V_ACTIVE   = 184,
  parameter int VS_START   = 4,
  parameter int VS_WIDTH   = 3,
  parameter int PLANE_SIZE = 4416
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce_pix,
  output logic [ADDR_WIDTH-1:0] vaddr,
  input  logic [7:0]            vdata,
`ifdef RX78_BORDER_COLOR_EN
  input  logic [2:0]            border_rgb,
`endif
  output logic                  r,
  output logic                  g,
  output logic                  b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  hblank,
  output logic                  vblank,
  output logic                  de
);

  localparam int HCW = $clog2(H_TOTAL);
  localparam int VCW = $clog2(V_TOTAL);
  localparam int BPL = H_ACTIVE / 8;
  localparam logic [ADDR_WIDTH-1:0] PLANE_STEP = ADDR_WIDTH'(PLANE_SIZE);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    WAIT = 3'd4
  } fetch_state_t;

  function automatic logic in_range(input logic [31:0] x, input int lo, input int len);
    return (x >= 32'(lo)) && (x < 32'(lo + len));
  endfunction

  fetch_state_t          state, state_nxt;
  logic [HCW-1:0]        hcnt, h_nxt, col;
  logic [VCW-1:0]        vcnt, v_nxt, row;
  logic [ADDR_WIDTH-1:0] vaddr_nxt, fetch_addr;
  logic [7:0]            hold0, hold1, hold2;
  logic [7:0]            shift0, shift1, shift2;
  logic                  in_window, fetch_start;
  logic                  cap0, cap1, cap2;
`ifdef RX78_BORDER_COLOR_EN
  logic [2:0]            border_q;
`endif

  always_comb begin
    h_nxt = hcnt + HCW'(1);
    v_nxt = vcnt;
    if (32'(hcnt) == H_TOTAL - 1) begin
      h_nxt = '0;
      v_nxt = (32'(vcnt) == V_TOTAL - 1) ? '0 : vcnt + VCW'(1);
    end
  end

  // The fetch window runs one character (8 pixels) ahead of the active columns.
  always_comb begin
    in_window   = in_range(32'(vcnt), V_START, V_ACTIVE) &&
                  in_range(32'(hcnt), H_START - 8, H_ACTIVE);
    col         = (hcnt - HCW'(H_START - 8)) >> 3;
    row         = vcnt - VCW'(V_START);
    fetch_addr  = ADDR_WIDTH'(32'(row) * BPL + 32'(col));
    fetch_start = ce_pix && in_window && (hcnt[2:0] == 3'd0);
  end

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    vaddr_nxt = vaddr;
    cap0      = 1'b0;
    cap1      = 1'b0;
    cap2      = 1'b0;
    unique case (state)
      P0: begin
        cap0      = 1'b1;
        vaddr_nxt = vaddr + PLANE_STEP;
        state_nxt = P1;
      end
      P1: begin
        cap1      = 1'b1;
        vaddr_nxt = vaddr + PLANE_STEP;
        state_nxt = P2;
      end
      P2: begin
        cap2      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (fetch_start) begin
      vaddr_nxt = fetch_addr;
      state_nxt = P0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      vaddr  <= '0;
      hcnt   <= '0;
      vcnt   <= '0;
      hold0  <= '0;
      hold1  <= '0;
      hold2  <= '0;
      shift0 <= '0;
      shift1 <= '0;
      shift2 <= '0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
      de     <= 1'b0;
`ifdef RX78_BORDER_COLOR_EN
      border_q <= '0;
`endif
    end else begin
      state <= state_nxt;
      vaddr <= vaddr_nxt;
      if (cap0) hold0 <= vdata;
      if (cap1) hold1 <= vdata;
      if (cap2) hold2 <= vdata;
      if (ce_pix) begin
        hcnt   <= h_nxt;
        vcnt   <= v_nxt;
        hsync  <= in_range(32'(h_nxt), HS_START, HS_WIDTH);
        vsync  <= in_range(32'(v_nxt), VS_START, VS_WIDTH);
        hblank <= !in_range(32'(h_nxt), H_START, H_ACTIVE);
        vblank <= !in_range(32'(v_nxt), V_START, V_ACTIVE);
        de     <= in_range(32'(h_nxt), H_START, H_ACTIVE) &&
                  in_range(32'(v_nxt), V_START, V_ACTIVE);
        if (hcnt[2:0] == 3'd7) begin
          shift0 <= in_window ? hold0 : 8'h00;
          shift1 <= in_window ? hold1 : 8'h00;
          shift2 <= in_window ? hold2 : 8'h00;
        end else begin
          shift0 <= {1'b0, shift0[7:1]};
          shift1 <= {1'b0, shift1[7:1]};
          shift2 <= {1'b0, shift2[7:1]};
        end
`ifdef RX78_BORDER_COLOR_EN
        border_q <= border_rgb;
`endif
      end
    end
  end

  always_comb begin
    {b, g, r} = 3'b000;
    if (de) begin
      {b, g, r} = {shift2[0], shift1[0], shift0[0]};
    end
`ifdef RX78_BORDER_COLOR_EN
    else if (!hsync && !vsync) begin
      {b, g, r} = border_q;
    end
`endif
  end

endmodule

// File: tb/tb_rx78_video_scan.sv
// Self-checking bench for rx78_video_scan: default-size instance for addresses/pixels/reset,
// reduced-size instance for whole-frame timing with irregular ce_pix spacing.
module tb_rx78_video_scan;

  typedef struct {
    int h_total, h_start, h_active, hs_start, hs_width;
    int v_total, v_start, v_active, vs_start, vs_width;
    int plane;
  } timing_t;

  typedef struct { int v; int h; int a0; int a1; int a2; } addr_vec_t;
  typedef struct { int v; int h; logic [2:0] rgb; } pix_vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce_a = 1'b0, ce_b = 1'b0;
  logic [13:0] vaddr_a;
  logic [7:0]  vaddr_b;
  logic [7:0]  vdata_a, vdata_b;
  logic r_a, g_a, b_a, hs_a, vs_a, hb_a, vb_a, de_a;
  logic r_b, g_b, b_b, hs_b, vs_b, hb_b, vb_b, de_b;
  logic [2:0] border_a = 3'b101;
  logic [2:0] border_b = 3'b011;

  logic [7:0] mem_a [16384];
  logic [7:0] mem_b [256];

  assign vdata_a = mem_a[vaddr_a];
  assign vdata_b = mem_b[vaddr_b];

  always #5 clk = ~clk;

  rx78_video_scan dut_a (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_a), .vaddr(vaddr_a), .vdata(vdata_a),
`ifdef RX78_BORDER_COLOR_EN
    .border_rgb(border_a),
`endif
    .r(r_a), .g(g_a), .b(b_a), .hsync(hs_a), .vsync(vs_a),
    .hblank(hb_a), .vblank(vb_a), .de(de_a)
  );

  rx78_video_scan #(
    .ADDR_WIDTH(8), .H_TOTAL(48), .H_START(16), .H_ACTIVE(24), .HS_START(2), .HS_WIDTH(4),
    .V_TOTAL(20), .V_START(5), .V_ACTIVE(10), .VS_START(1), .VS_WIDTH(2), .PLANE_SIZE(30)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_b), .vaddr(vaddr_b), .vdata(vdata_b),
`ifdef RX78_BORDER_COLOR_EN
    .border_rgb(border_b),
`endif
    .r(r_b), .g(g_b), .b(b_b), .hsync(hs_b), .vsync(vs_b),
    .hblank(hb_b), .vblank(vb_b), .de(de_b)
  );

  timing_t   t_a, t_b;
  addr_vec_t addr_tbl [2];
  pix_vec_t  pix_tbl [8];
  int        checks = 0;
  int        errors = 0;
  int        mh, mv;
  logic [2:0] brd_q;
  int        addr_q [$];
  int        tbl_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (pos v=%0d h=%0d, t=%0t)", name, act, exp, mv, mh, $time);
    end
  endtask

  // Expected {r,g,b,hsync,vsync,hblank,vblank,de} for a raster position, straight from the timing rules.
  function automatic logic [7:0] model(input timing_t t, input int h, input int v,
                                       input logic [2:0] brd, input bit sel_b);
    logic hs, vs, hb, vb, de;
    logic [2:0] rgb;
    logic [7:0] byt;
    int addr;
    hs  = (h >= t.hs_start) && (h < t.hs_start + t.hs_width);
    vs  = (v >= t.vs_start) && (v < t.vs_start + t.vs_width);
    hb  = !((h >= t.h_start) && (h < t.h_start + t.h_active));
    vb  = !((v >= t.v_start) && (v < t.v_start + t.v_active));
    de  = !hb && !vb;
    rgb = 3'b000;
    if (de) begin
      for (int p = 0; p < 3; p++) begin
        addr = p * t.plane + (v - t.v_start) * (t.h_active / 8) + (h - t.h_start) / 8;
        byt  = sel_b ? mem_b[addr % 256] : mem_a[addr % 16384];
        rgb[p] = byt[(h - t.h_start) % 8];
      end
    end
`ifdef RX78_BORDER_COLOR_EN
    else if (!hs && !vs) begin
      rgb = brd;
    end
`else
    if (brd == 3'b111 && de && 1'b0) rgb = 3'b000;
`endif
    return {rgb[0], rgb[1], rgb[2], hs, vs, hb, vb, de};
  endfunction

  // One clk on the selected instance; ce marks a pixel tick.
  task automatic step(input bit sel_b, input bit ce);
    timing_t t;
    int oh, ov, base, mask;
    logic [7:0] act;
    logic [31:0] act_addr;
    ce_a = !sel_b && ce;
    ce_b = sel_b && ce;
    @(posedge clk);
    #1;
    t    = sel_b ? t_b : t_a;
    mask = sel_b ? 255 : 16383;
    if (ce) begin
      oh = mh;
      ov = mv;
      mh++;
      if (mh == t.h_total) begin
        mh = 0;
        mv++;
        if (mv == t.v_total) mv = 0;
      end
      brd_q = sel_b ? border_b : border_a;
      if (ov >= t.v_start && ov < t.v_start + t.v_active &&
          oh >= t.h_start - 8 && oh < t.h_start + t.h_active - 8 &&
          (oh - (t.h_start - 8)) % 8 == 0) begin
        base = (ov - t.v_start) * (t.h_active / 8) + (oh - (t.h_start - 8)) / 8;
        addr_q.push_back(base & mask);
        addr_q.push_back((base + t.plane) & mask);
        addr_q.push_back((base + 2 * t.plane) & mask);
      end
      if (!sel_b) begin
        for (int i = 0; i < 2; i++) begin
          if (addr_tbl[i].v == ov && addr_tbl[i].h == oh) begin
            tbl_q.push_back(addr_tbl[i].a0);
            tbl_q.push_back(addr_tbl[i].a1);
            tbl_q.push_back(addr_tbl[i].a2);
          end
        end
      end
    end
    act      = sel_b ? {r_b, g_b, b_b, hs_b, vs_b, hb_b, vb_b, de_b}
                     : {r_a, g_a, b_a, hs_a, vs_a, hb_a, vb_a, de_a};
    act_addr = sel_b ? 32'(vaddr_b) : 32'(vaddr_a);
    check(sel_b ? "out_b" : "out_a", 32'(act), 32'(model(t, mh, mv, brd_q, sel_b)));
    if (addr_q.size() > 0) check("vaddr_fetch", act_addr, addr_q.pop_front());
    if (tbl_q.size() > 0)  check("vaddr_table", act_addr, tbl_q.pop_front());
    if (!sel_b && ce) begin
      for (int i = 0; i < 8; i++) begin
        if (pix_tbl[i].v == mv && pix_tbl[i].h == mh) check("pixel_table", 32'(act[7:5]), 32'(pix_tbl[i].rgb));
      end
`ifdef RX78_BORDER_COLOR_EN
      if (mv == 50 && mh == 50) check("border_colour", 32'(act[7:5]), 32'h5);
      if (mv == 50 && mh == 10) check("border_in_sync", 32'(act[7:5]), 32'h0);
`endif
    end
  endtask

  task automatic check_reset_state(input string name);
    check(name, 32'({r_a, g_a, b_a, hs_a, vs_a, hb_a, vb_a, de_a}), 32'h06);
    check({name, "_vaddr"}, 32'(vaddr_a), 32'h0);
  endtask

  initial begin
    int rises, ticks, de_cnt, hs_cnt, gaps;
    logic prev_vs;

    t_a = '{h_total:320, h_start:80, h_active:192, hs_start:8, hs_width:24,
            v_total:262, v_start:40, v_active:184, vs_start:4, vs_width:3, plane:4416};
    t_b = '{h_total:48, h_start:16, h_active:24, hs_start:2, hs_width:4,
            v_total:20, v_start:5, v_active:10, vs_start:1, vs_width:2, plane:30};
    addr_tbl[0] = '{v:40, h:72,  a0:0,  a1:4416, a2:8832};
    addr_tbl[1] = '{v:41, h:256, a0:47, a1:4463, a2:8879};
    pix_tbl[0] = '{v:40, h:80, rgb:3'b101};
    for (int i = 1; i < 7; i++) pix_tbl[i] = '{v:40, h:80 + i, rgb:3'b001};
    pix_tbl[7] = '{v:40, h:87, rgb:3'b011};

    for (int i = 0; i < 16384; i++) mem_a[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)   mem_b[i] = 8'($urandom);
    mem_a[0]    = 8'h01;
    mem_a[4416] = 8'h80;
    mem_a[8832] = 8'hFF;

    // Reset held with ce_pix toggling: everything stays at reset values.
    for (int i = 0; i < 8; i++) begin
      ce_a = ~ce_a;
      ce_b = ce_a;
      @(posedge clk);
      #1;
      check_reset_state("reset_hold");
      check("reset_hold_b", 32'({r_b, g_b, b_b, hs_b, vs_b, hb_b, vb_b, de_b}), 32'h06);
    end
    ce_a = 1'b0;
    ce_b = 1'b0;
    reset_n = 1'b1;
    mh = 0; mv = 0; brd_q = 3'b000;

    // Run to the tick that starts the fetch at vcnt=100, hcnt=152.
    for (int i = 0; i < 100 * 320 + 153; i++) step(1'b0, 1'b1);
    ce_a = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_pulse");
    reset_n = 1'b1;
    mh = 0; mv = 0; brd_q = 3'b000;
    addr_q.delete();
    tbl_q.delete();

    // Rescan from (0,0) through the first active lines.
    for (int i = 0; i < 41 * 320 + 100; i++) step(1'b0, 1'b1);
    addr_q.delete();
    tbl_q.delete();

    // Reduced-size instance: whole-frame timing, first frame every 4th clk, then random spacing.
    mh = 0; mv = 0; brd_q = 3'b000;
    rises = 0; ticks = 0; de_cnt = 0; hs_cnt = 0; prev_vs = 1'b0;
    for (int k = 0; k < 2100; k++) begin
      step(1'b1, 1'b1);
      if (vs_b && !prev_vs) begin
        if (rises > 0) begin
          check("frame_ticks", ticks, 48 * 20);
          check("frame_de_ticks", de_cnt, 24 * 10);
          check("frame_hsync_ticks", hs_cnt, 4 * 20);
        end
        rises++;
        ticks = 0; de_cnt = 0; hs_cnt = 0;
      end
      prev_vs = vs_b;
      ticks++;
      if (de_b) de_cnt++;
      if (hs_b) hs_cnt++;
      gaps = (k < 960) ? 3 : int'($urandom_range(0, 4));
      for (int j = 0; j < gaps; j++) step(1'b1, 1'b0);
    end
    check("frame_count", rises, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
